// File: rtl/tile_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tile_spawn_ctrl
// Brief    : Picks an empty 2048 board cell (LFSR start + linear probe) and
//            drives the fill handshake. Optional macro SPAWN_SEED_LOAD_EN adds
//            a runtime LFSR seed load (seed_load / seed_in).
// Revision : 1.0
// ============================================================================
module tile_spawn_ctrl #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_req,
    input  logic [79:0] cell_all,
`ifdef SPAWN_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed_in,
`endif
    output logic [3:0]  random_pos,
    output logic [5:0]  random_prob,
    output logic        fill_start,
    input  logic        calc_done,
    output logic        spawn_done,
    output logic        board_full,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] c_seed  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          c_cnt_w = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_full  = 3'd1;
    localparam logic [2:0] c_pick  = 3'd2;
    localparam logic [2:0] c_issue = 3'd3;
    localparam logic [2:0] c_wait  = 3'd4;
    localparam logic [2:0] c_done  = 3'd5;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [79:0]        board_q;
    logic [3:0]         pos_q;
    logic [5:0]         prob_q;
    logic [3:0]         out_pos_q;
    logic [5:0]         out_prob_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               board_full_q;
    logic               timeout_err_q;

    logic [15:0]        w_in_empty;
    logic [15:0]        w_q_empty;
    logic [15:0]        w_lfsr_shift;
    logic               w_board_full;
    logic               w_pick_empty;
    logic               w_timeout;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cells
            assign w_in_empty[gi] = (cell_all[5*gi +: 5] == 5'd0);
            assign w_q_empty[gi]  = (board_q[5*gi +: 5] == 5'd0);
        end
    endgenerate

    assign w_board_full = ~|w_in_empty;
    assign w_pick_empty = w_q_empty[pos_q];
    assign w_timeout    = (cnt_q == c_cnt_w'(TIMEOUT - 1));
    assign w_lfsr_shift = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SPAWN_SEED_LOAD_EN
    // A zero seed would lock the LFSR, so it is forced to 1.
    assign lfsr_d = seed_load ? ((seed_in == 16'h0000) ? 16'h0001 : seed_in) : w_lfsr_shift;
`else
    assign lfsr_d = w_lfsr_shift;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle: begin
                if (spawn_req) begin
                    state_d = w_board_full ? c_full : c_pick;
                end
            end
            c_full:  state_d = c_idle;
            c_pick: begin
                if (w_pick_empty) begin
                    state_d = c_issue;
                end
            end
            c_issue: state_d = c_wait;
            c_wait: begin
                if (calc_done || w_timeout) begin
                    state_d = c_done;
                end
            end
            c_done:  state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        busy       = (state_q != c_idle);
        fill_start = (state_q == c_issue);
        spawn_done = (state_q == c_full) || (state_q == c_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q        <= c_seed;
            board_q       <= '0;
            pos_q         <= '0;
            prob_q        <= '0;
            out_pos_q     <= '0;
            out_prob_q    <= '0;
            cnt_q         <= '0;
            board_full_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                c_idle: begin
                    if (spawn_req) begin
                        board_q       <= cell_all;
                        timeout_err_q <= 1'b0;
                        if (w_board_full) begin
                            board_full_q <= 1'b1;
                        end else begin
                            pos_q  <= lfsr_q[3:0];
                            prob_q <= lfsr_q[9:4];
                        end
                    end
                end
                c_pick: begin
                    // Outputs are loaded here so they are already valid while fill_start is high.
                    if (w_pick_empty) begin
                        out_pos_q  <= pos_q;
                        out_prob_q <= prob_q;
                    end else begin
                        pos_q <= pos_q + 4'd1;
                    end
                end
                c_issue: begin
                    board_full_q <= 1'b0;
                    cnt_q        <= '0;
                end
                c_wait: begin
                    if (!calc_done) begin
                        if (w_timeout) begin
                            timeout_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign random_pos  = out_pos_q;
    assign random_prob = out_prob_q;
    assign board_full  = board_full_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_spawn_ctrl
// Brief    : Directed self-checking bench for tile_spawn_ctrl.
// Revision : 1.0
// ============================================================================
module tb_tile_spawn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_req;
    logic [79:0] cell_all;
    logic [3:0]  random_pos;
    logic [5:0]  random_prob;
    logic        fill_start;
    logic        calc_done;
    logic        spawn_done;
    logic        board_full;
    logic        busy;
    logic        timeout_err;
`ifdef SPAWN_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_in;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    tile_spawn_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spawn_req   (spawn_req),
        .cell_all    (cell_all),
`ifdef SPAWN_SEED_LOAD_EN
        .seed_load   (seed_load),
        .seed_in     (seed_in),
`endif
        .random_pos  (random_pos),
        .random_prob (random_prob),
        .fill_start  (fill_start),
        .calc_done   (calc_done),
        .spawn_done  (spawn_done),
        .board_full  (board_full),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Reference LFSR, used to predict the probe start and the prob value.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
        end
`ifdef SPAWN_SEED_LOAD_EN
        else if (seed_load) begin
            m_lfsr <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
        end
`endif
        else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // cd_delay > 0: calc_done raised cd_delay cycles after fill_start.
    // cd_delay < 0: calc_done only pulsed alongside fill_start, so the wait must time out.
    task automatic do_spawn(input string tag, input logic [79:0] board, input int cd_delay);
        logic [3:0] start;
        logic [3:0] exp_pos;
        logic [5:0] exp_prob;
        int         n;
        int         cyc;
        int         pulses;
        bit         full;
        full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (board[5*i +: 5] == 5'd0) full = 1'b0;
        end
        cell_all  = board;
        spawn_req = 1'b1;
        start     = m_lfsr[3:0];
        exp_prob  = m_lfsr[9:4];
        tick;
        spawn_req = 1'b0;
        cell_all  = '0;
        chk({tag, "_err_clr"}, timeout_err, 0);
        if (full) begin
            chk({tag, "_done"}, spawn_done, 1);
            chk({tag, "_full"}, board_full, 1);
            chk({tag, "_nofill"}, fill_start, 0);
            tick;
            chk({tag, "_done_end"}, spawn_done, 0);
            chk({tag, "_idle"}, busy, 0);
            return;
        end
        n       = 0;
        exp_pos = start;
        while (board[exp_pos*5 +: 5] != 5'd0 && n < 16) begin
            exp_pos = exp_pos + 4'd1;
            n++;
        end
        cyc = 1;
        while (!fill_start && cyc < 24) begin
            tick;
            cyc++;
        end
        chk({tag, "_issue_lat"}, cyc, n + 2);
        chk({tag, "_pos"}, random_pos, exp_pos);
        chk({tag, "_prob"}, random_prob, exp_prob);
        if (cd_delay < 0) calc_done = 1'b1;
        tick;
        calc_done = 1'b0;
        chk({tag, "_fill_1cyc"}, fill_start, 0);
        chk({tag, "_full_clr"}, board_full, 0);
        chk({tag, "_pos_hold"}, random_pos, exp_pos);
        if (cd_delay > 0) begin
            for (int i = 1; i < cd_delay; i++) tick;
            calc_done = 1'b1;
            tick;
            calc_done = 1'b0;
            chk({tag, "_done"}, spawn_done, 1);
            chk({tag, "_no_tmo"}, timeout_err, 0);
            tick;
            chk({tag, "_done_end"}, spawn_done, 0);
            chk({tag, "_idle"}, busy, 0);
        end else begin
            cyc = 0;
            while (!spawn_done && cyc < 40) begin
                spawn_req = (cyc < 8) ? cyc[0] : 1'b0;
                tick;
                cyc++;
            end
            spawn_req = 1'b0;
            chk({tag, "_tmo_wait"}, cyc, 16);
            chk({tag, "_tmo_err"}, timeout_err, 1);
            chk({tag, "_prob_hold"}, random_prob, exp_prob);
            tick;
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                if (spawn_done || busy) pulses++;
                tick;
            end
            chk({tag, "_no_extra"}, pulses, 0);
            chk({tag, "_err_sticky"}, timeout_err, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] b;
        int          pulses;
        rst_n     = 1'b0;
        spawn_req = 1'b0;
        cell_all  = '0;
        calc_done = 1'b0;
`ifdef SPAWN_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = 16'h0000;
`endif
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill_start, 0);
        chk("rst_done", spawn_done, 0);
        chk("rst_full", board_full, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_pos", random_pos, 0);
        chk("rst_prob", random_prob, 0);
        rst_n = 1'b1;
        tick;

        do_spawn("cells012", {{13{5'd1}}, {3{5'd0}}}, 2);
        chk("cells012_range", (random_pos <= 4'd2), 1);

        do_spawn("cell15", {5'd0, {15{5'd1}}}, 1);
        chk("cell15_pos", random_pos, 15);

        do_spawn("full", {16{5'd1}}, 1);
        chk("full_held", board_full, 1);

        b           = {16{5'd1}};
        b[35 +: 5]  = 5'd0;
        do_spawn("after_full", b, 3);
        chk("after_full_pos", random_pos, 7);

        do_spawn("empty", '0, 1);

        do_spawn("tmo", {5'd0, {15{5'd2}}}, -1);
        do_spawn("post_tmo", '0, 1);

        // Reset while waiting for calc_done.
        cell_all  = {5'd0, {15{5'd1}}};
        spawn_req = 1'b1;
        tick;
        spawn_req = 1'b0;
        for (int i = 0; i < 24 && !fill_start; i++) tick;
        tick;
        chk("abort_in_wait", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_fill", fill_start, 0);
        chk("abort_pos", random_pos, 0);
        chk("abort_done", spawn_done, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (spawn_done) pulses++;
        end
        chk("abort_no_done", pulses, 0);

`ifdef SPAWN_SEED_LOAD_EN
        // Request is sampled while lfsr holds 16'h0005; it only becomes 16'h000A on that same edge.
        seed_load = 1'b1;
        seed_in   = 16'h0005;
        tick;
        seed_load = 1'b0;
        do_spawn("seed", '0, 1);
        chk("seed_pos_explicit", random_pos, 4'h5);
        chk("seed_prob_explicit", random_prob, 6'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
